// File: rtl/saber_seq_pkg.sv
// Shared definitions for the SABER command sequencer: entry kinds, core
// opcodes, done-line indices, FSM states and entry field extraction helpers.
package saber_seq_pkg;

    localparam logic [1:0] KIND_EXEC = 2'b00;
    localparam logic [1:0] KIND_CFG  = 2'b01;
    localparam logic [1:0] KIND_NOP  = 2'b10;
    localparam logic [1:0] KIND_HALT = 2'b11;

    localparam int OP_SHAKE_CFG  = 0;
    localparam int OP_SHA3       = 2;
    localparam int OP_SHAKE      = 3;
    localparam int OP_BS2POLVECP = 9;
    localparam int OP_VMUL       = 10;
    localparam int OP_UNPACK     = 11;
    localparam int OP_COPY       = 12;

    localparam int DONE_SHAKE      = 0;
    localparam int DONE_VMUL       = 1;
    localparam int DONE_ADDROUND   = 2;
    localparam int DONE_ADDPACK    = 3;
    localparam int DONE_BS2POLVECP = 4;
    localparam int DONE_UNPACK     = 5;
    localparam int DONE_COPY       = 6;
    localparam int DONE_SPARE      = 7;

    // Entries are widened to this container so the helpers work for any
    // parameterisation of the sequencer.
    localparam int ENTRY_MAX_W = 128;
    typedef logic [ENTRY_MAX_W-1:0] entry_wide_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_PRIME,
        S_ISSUE,
        S_WAIT_HI,
        S_SETTLE,
        S_CLEAR,
        S_WAIT_LO,
        S_NEXT,
        S_ERR_CLR
    } seq_state_e;

    function automatic logic [1:0] entry_kind(input entry_wide_t e,
                                              input int unsigned dsel_w,
                                              input int unsigned cmd_w);
        entry_wide_t shifted;
        shifted = e >> (dsel_w + cmd_w);
        return shifted[1:0];
    endfunction

    function automatic entry_wide_t entry_dsel(input entry_wide_t e,
                                               input int unsigned dsel_w,
                                               input int unsigned cmd_w);
        return (e >> cmd_w) & ((entry_wide_t'(1) << dsel_w) - entry_wide_t'(1));
    endfunction

    function automatic entry_wide_t entry_payload(input entry_wide_t e,
                                                  input int unsigned cmd_w);
        return e & ((entry_wide_t'(1) << cmd_w) - entry_wide_t'(1));
    endfunction

    // Opcodes beyond the 32-bit mask never need a prime cycle.
    function automatic logic op_needs_prime(input logic [31:0] mask,
                                            input logic [31:0] op);
        return (op < 32) ? mask[op[4:0]] : 1'b0;
    endfunction

endpackage

// File: rtl/saber_cmd_sequencer_if.sv
// Command/done handshake between the sequencer and the SABER compute core.
interface saber_cmd_sequencer_if #(
    parameter int CMD_W  = 35,
    parameter int N_DONE = 8
);
    logic [CMD_W-1:0]  cmd_out;
    logic              cmd_we0;
    logic              cmd_we1;
    logic [N_DONE-1:0] done_in;

    modport master (output cmd_out, cmd_we0, cmd_we1, input done_in);
    modport slave  (input cmd_out, cmd_we0, cmd_we1, output done_in);
endinterface

// File: rtl/saber_seq_prog_ram.sv
// Single-port program RAM with one-cycle registered read.
module saber_seq_prog_ram #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 40,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Write port and registered read share the single address.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end
endmodule

// File: rtl/saber_cmd_sequencer.sv
// Program-driven command sequencer: fetches entries from the program RAM,
// issues them to the core, waits on the selected done line and clears.
module saber_cmd_sequencer
    import saber_seq_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter int          OP_W      = 5,
    parameter int          DEPTH     = 32,
    parameter int          N_DONE    = 8,
    parameter logic [31:0] SHAKE_OPS = 32'h0000_000C,
    parameter int          TIMEOUT_W = 20,
    localparam int PC_W    = $clog2(DEPTH),
    localparam int DSEL_W  = $clog2(N_DONE),
    localparam int CMD_W   = 3 * ADDR_W + OP_W,
    localparam int ENTRY_W = 2 + DSEL_W + CMD_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  prog_we,
    input  logic [PC_W-1:0]       prog_addr,
    input  logic [ENTRY_W-1:0]    prog_wdata,
    input  logic                  start,
    input  logic [PC_W-1:0]       start_pc,
    input  logic                  abort,
    saber_cmd_sequencer_if.master core,
    output logic                  busy,
    output logic                  seq_done,
    output logic                  seq_err,
    output logic [PC_W-1:0]       pc
);
    seq_state_e           state_reg, state_next;
    logic [PC_W-1:0]      pc_reg, pc_next;
    logic                 seq_err_reg, seq_err_next;
    logic [TIMEOUT_W-1:0] wdog_reg, wdog_next, wdog_inc;
    logic [CMD_W-1:0]     hold_reg;   // last value presented on cmd_out
    logic [CMD_W-1:0]     cmd_next;
    logic                 we0_next, we1_next, done_pulse;

    logic                 ram_we;
    logic [PC_W-1:0]      ram_addr;
    logic [ENTRY_W-1:0]   rd_data;
    entry_wide_t          entry_wide;
    logic [1:0]           kind;
    logic [DSEL_W-1:0]    dsel;
    logic [CMD_W-1:0]     payload, payload_noop;
    logic                 op_prime, done_sel, timeout;
    logic [N_DONE-1:0]    done_hit;

    // The program can only be edited while idle, so the RAM address simply
    // follows pc whenever a program is running.
    assign ram_we   = prog_we && (state_reg == S_IDLE);
    assign ram_addr = (state_reg == S_IDLE) ? prog_addr : pc_reg;

    saber_seq_prog_ram #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_prog_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (prog_wdata),
        .rdata (rd_data)
    );

    // RAM output stays stable for the whole entry since pc only moves in NEXT.
    assign entry_wide   = entry_wide_t'(rd_data);
    assign kind         = entry_kind(entry_wide, DSEL_W, CMD_W);
    assign dsel         = DSEL_W'(entry_dsel(entry_wide, DSEL_W, CMD_W));
    assign payload      = CMD_W'(entry_payload(entry_wide, CMD_W));
    assign payload_noop = {payload[CMD_W-1:OP_W], OP_W'(OP_SHAKE_CFG)};
    assign op_prime     = op_needs_prime(SHAKE_OPS, 32'(payload[OP_W-1:0]));

    for (genvar gi = 0; gi < N_DONE; gi++) begin : g_done_sel
        assign done_hit[gi] = core.done_in[gi] && (dsel == DSEL_W'(gi));
    end
    assign done_sel = |done_hit;

    // Timeout fires on the wait cycle in which the counter becomes all-ones.
    assign wdog_inc = wdog_reg + TIMEOUT_W'(1);
    assign timeout  = &wdog_inc;

    // Next-state, strobe and status decode.
    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        seq_err_next = seq_err_reg;
        cmd_next     = hold_reg;
        we0_next     = 1'b0;
        we1_next     = 1'b0;
        done_pulse   = 1'b0;
        unique case (state_reg)
            S_IDLE: begin
                if (start) begin
                    pc_next      = start_pc;
                    seq_err_next = 1'b0;
                    state_next   = S_FETCH;
                end
            end
            S_FETCH: state_next = S_DECODE;
            S_DECODE: begin
                unique case (kind)
                    KIND_HALT: begin
                        done_pulse = 1'b1;
                        state_next = S_IDLE;
                    end
                    KIND_NOP: state_next = S_NEXT;
                    KIND_CFG: begin
                        cmd_next   = payload;
                        we1_next   = 1'b1;
                        state_next = S_NEXT;
                    end
                    default: state_next = op_prime ? S_PRIME : S_ISSUE;
                endcase
            end
            S_PRIME: begin
                cmd_next   = payload_noop;
                we0_next   = 1'b1;
                state_next = S_ISSUE;
            end
            S_ISSUE: begin
                cmd_next   = payload;
                we0_next   = 1'b1;
                state_next = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (done_sel)     state_next = S_SETTLE;
                else if (timeout) state_next = S_ERR_CLR;
            end
            S_SETTLE: state_next = S_CLEAR;
            S_CLEAR: begin
                cmd_next   = '0;
                we0_next   = 1'b1;
                state_next = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                if (!done_sel)    state_next = S_NEXT;
                else if (timeout) state_next = S_ERR_CLR;
            end
            S_NEXT: begin
                if (&pc_reg) begin
                    done_pulse = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    pc_next    = pc_reg + PC_W'(1);
                    state_next = S_FETCH;
                end
            end
            S_ERR_CLR: begin
                cmd_next     = '0;
                we0_next     = 1'b1;
                seq_err_next = 1'b1;
                state_next   = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        // Abort lets this cycle's strobe complete, then diverts to ERR_CLR.
        if (abort && state_reg != S_IDLE && state_reg != S_ERR_CLR) begin
            state_next = S_ERR_CLR;
            pc_next    = pc_reg;
            done_pulse = 1'b0;
        end
        // The watchdog restarts whenever the state changes.
        wdog_next = (state_next != state_reg) ? '0 : wdog_inc;
    end

    // State, pc, status and held-command registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            pc_reg      <= '0;
            seq_err_reg <= 1'b0;
            wdog_reg    <= '0;
            hold_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            seq_err_reg <= seq_err_next;
            wdog_reg    <= wdog_next;
            hold_reg    <= cmd_next;
        end
    end

    assign core.cmd_out = cmd_next;
    assign core.cmd_we0 = we0_next;
    assign core.cmd_we1 = we1_next;
    assign busy         = (state_reg != S_IDLE);
    assign seq_done     = done_pulse;
    assign seq_err      = seq_err_reg;
    assign pc           = pc_reg;
endmodule

// File: tb/tb_saber_cmd_sequencer.sv
// Scoreboard bench for saber_cmd_sequencer with a small core done-line model.
module tb_saber_cmd_sequencer;
    import saber_seq_pkg::*;

    localparam int CMD_W = 35;
    localparam int ENTRY_W = 40;

    typedef struct packed {
        logic             we1;
        logic [CMD_W-1:0] cmd;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       prog_we = 1'b0;
    logic [4:0] prog_addr = '0;
    logic [ENTRY_W-1:0] prog_wdata = '0;
    logic       start = 1'b0;
    logic [4:0] start_pc = '0;
    logic       abort = 1'b0;
    logic       busy, seq_done, seq_err;
    logic [4:0] pc;

    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    bit   model_en = 1'b1;
    bit   drop_en = 1'b1;
    int   hi_cnt = 0;
    int   lo_cnt = 0;
    int   act_idx = 0;

    saber_cmd_sequencer_if #(.CMD_W(CMD_W), .N_DONE(8)) core_if ();

    saber_cmd_sequencer #(
        .ADDR_W(10), .OP_W(5), .DEPTH(32), .N_DONE(8),
        .SHAKE_OPS(32'h0000_000C), .TIMEOUT_W(4)
    ) dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata), .start(start), .start_pc(start_pc),
        .abort(abort), .core(core_if), .busy(busy), .seq_done(seq_done),
        .seq_err(seq_err), .pc(pc)
    );

    always #5 clk = ~clk;

    function automatic logic [CMD_W-1:0] mk(input int d, input int s2, input int s1, input int op);
        return {10'(d), 10'(s2), 10'(s1), 5'(op)};
    endfunction

    function automatic logic [ENTRY_W-1:0] ent(input logic [1:0] k, input logic [2:0] ds,
                                               input logic [CMD_W-1:0] p);
        return {k, ds, p};
    endfunction

    function automatic int done_idx(input logic [4:0] op);
        case (op)
            5'd12:       return 6;
            5'd11:       return 5;
            5'd10:       return 1;
            5'd9:        return 4;
            5'd2, 5'd3:  return 0;
            default:     return 7;
        endcase
    endfunction

    // Core model: done rises ~5 cycles after a real issue, falls 2 after a clear.
    always @(posedge clk) begin
        if (rst || !model_en) begin
            core_if.done_in <= '0;
            hi_cnt <= 0;
            lo_cnt <= 0;
        end else begin
            if (core_if.cmd_we0 && core_if.cmd_out == '0) begin
                lo_cnt <= 2;
            end else if (core_if.cmd_we0 && core_if.cmd_out[4:0] != 5'd0) begin
                hi_cnt  <= 5;
                act_idx <= done_idx(core_if.cmd_out[4:0]);
            end
            if (hi_cnt > 0) begin
                hi_cnt <= hi_cnt - 1;
                if (hi_cnt == 1) core_if.done_in[act_idx] <= 1'b1;
            end
            if (lo_cnt > 0) begin
                lo_cnt <= lo_cnt - 1;
                if (lo_cnt == 1 && drop_en) core_if.done_in <= '0;
            end
        end
    end

    // Monitor: every command strobe is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (seq_done) done_cnt <= done_cnt + 1;
        if (core_if.cmd_we0 || core_if.cmd_we1) begin
            checks++;
            $display("[%0t] cmd we0=%0b we1=%0b data=%h", $time,
                     core_if.cmd_we0, core_if.cmd_we1, core_if.cmd_out);
            if (core_if.cmd_we0 && core_if.cmd_we1) begin
                errors++;
                $display("FAIL we_exclusive: actual we0=1 we1=1, required at most one");
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_cmd: actual we1=%0b data=%h, required no command",
                         core_if.cmd_we1, core_if.cmd_out);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.we1 !== core_if.cmd_we1 || mon_e.cmd !== core_if.cmd_out) begin
                    errors++;
                    $display("FAIL cmd_seq: actual we1=%0b data=%h, required we1=%0b data=%h",
                             core_if.cmd_we1, core_if.cmd_out, mon_e.we1, mon_e.cmd);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push(input logic we1, input logic [CMD_W-1:0] cmd);
        exp_t e;
        e.we1 = we1;
        e.cmd = cmd;
        exp_q.push_back(e);
    endtask

    task automatic write_entry(input logic [4:0] a, input logic [ENTRY_W-1:0] d);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = a; prog_wdata = d;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic pulse_start(input logic [4:0] p);
        @(negedge clk);
        start = 1'b1; start_pc = p;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_seq_done(input string name, input int budget);
        int i = 0;
        while (!seq_done && i < budget) begin
            @(negedge clk);
            i++;
        end
        check({name, "_seq_done"}, 64'(seq_done), 64'd1);
    endtask

    // Waits for the next we0 strobe (optionally only a zero command).
    task automatic wait_strobe(input string name, input bit want_zero, input int budget,
                               output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!(core_if.cmd_we0 && (!want_zero || core_if.cmd_out == '0)) && cycles < budget);
        check({name, "_strobe_seen"}, 64'(core_if.cmd_we0), 64'd1);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_cmd_out"}, 64'(core_if.cmd_out), 64'd0);
        check({name, "_we"}, {62'd0, core_if.cmd_we0, core_if.cmd_we1}, 64'd0);
        check({name, "_busy"}, 64'(busy), 64'd0);
        check({name, "_seq_done"}, 64'(seq_done), 64'd0);
        check({name, "_seq_err"}, 64'(seq_err), 64'd0);
        check({name, "_pc"}, 64'(pc), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

    initial begin
        int base;
        int cyc;

        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Copy program; start and prog_we while busy must be ignored.
        write_entry(5'd0, ent(KIND_EXEC, 3'd6, 35'h4_0802_198C));
        write_entry(5'd1, ent(KIND_HALT, 3'd0, '0));
        push(1'b0, 35'h4_0802_198C);
        push(1'b0, '0);
        base = done_cnt;
        pulse_start(5'd0);
        prog_we = 1'b1; prog_addr = 5'd1; prog_wdata = ent(KIND_EXEC, 3'd1, mk(9, 9, 9, 10));
        start = 1'b1; start_pc = 5'd5;
        @(negedge clk);
        prog_we = 1'b0; start = 1'b0;
        wait_seq_done("copy", 80);
        check("copy_busy_at_done", 64'(busy), 64'd1);
        @(negedge clk);
        check("copy_busy_fall", 64'(busy), 64'd0);
        check("copy_done_count", 64'(done_cnt - base), 64'd1);
        check("copy_pc", 64'(pc), 64'd1);
        check("copy_seq_err", 64'(seq_err), 64'd0);

        // Entry 1 must still be HALT: no commands, pc stays 1.
        pulse_start(5'd1);
        wait_seq_done("ram_unchanged", 10);
        @(negedge clk);
        check("ram_unchanged_pc", 64'(pc), 64'd1);

        // SHA3: CFG via we1, then prime (op 0), issue (op 2), clear.
        write_entry(5'd10, ent(KIND_CFG, 3'd0, 35'h0_0040_0040));
        write_entry(5'd11, ent(KIND_EXEC, 3'd0, mk(512, 0, 512, 2)));
        write_entry(5'd12, ent(KIND_HALT, 3'd0, '0));
        push(1'b1, 35'h0_0040_0040);
        push(1'b0, mk(512, 0, 512, 0));
        push(1'b0, mk(512, 0, 512, 2));
        push(1'b0, '0);
        pulse_start(5'd10);
        wait_strobe("sha3_prime", 1'b0, 30, cyc);
        check("sha3_prime_cmd", 64'(core_if.cmd_out), 64'(mk(512, 0, 512, 0)));
        @(negedge clk);
        check("sha3_issue_next_cycle", {63'd0, core_if.cmd_we0}, 64'd1);
        wait_seq_done("sha3", 80);
        @(negedge clk);
        check("sha3_pc", 64'(pc), 64'd12);

        // Decrypt chain from pc 4
        write_entry(5'd4, ent(KIND_EXEC, 3'd4, mk(100, 200, 300, 9)));
        write_entry(5'd5, ent(KIND_EXEC, 3'd1, mk(101, 201, 301, 10)));
        write_entry(5'd6, ent(KIND_EXEC, 3'd5, mk(102, 0, 302, 11)));
        write_entry(5'd7, ent(KIND_EXEC, 3'd6, mk(103, 0, 303, 12)));
        write_entry(5'd8, ent(KIND_EXEC, 3'd0, mk(104, 0, 304, 3)));
        write_entry(5'd9, ent(KIND_HALT, 3'd0, '0));
        push(1'b0, mk(100, 200, 300, 9));  push(1'b0, '0);
        push(1'b0, mk(101, 201, 301, 10)); push(1'b0, '0);
        push(1'b0, mk(102, 0, 302, 11));   push(1'b0, '0);
        push(1'b0, mk(103, 0, 303, 12));   push(1'b0, '0);
        push(1'b0, mk(104, 0, 304, 0));
        push(1'b0, mk(104, 0, 304, 3));    push(1'b0, '0);
        base = done_cnt;
        pulse_start(5'd4);
        wait_seq_done("chain", 300);
        @(negedge clk);
        check("chain_pc", 64'(pc), 64'd9);
        check("chain_done_count", 64'(done_cnt - base), 64'd1);

        // Timeout: 15 WAIT_HI cycles, so ERR_CLR comes 16 cycles after ISSUE.
        model_en = 1'b0;
        write_entry(5'd20, ent(KIND_EXEC, 3'd1, mk(7, 8, 9, 10)));
        write_entry(5'd21, ent(KIND_HALT, 3'd0, '0));
        write_entry(5'd31, ent(KIND_NOP, 3'd0, '0));
        push(1'b0, mk(7, 8, 9, 10));
        push(1'b0, '0);
        base = done_cnt;
        pulse_start(5'd20);
        wait_strobe("timeout_issue", 1'b0, 10, cyc);
        wait_strobe("timeout_errclr", 1'b1, 40, cyc);
        check("timeout_latency", 64'(cyc), 64'd16);
        @(negedge clk);
        check("timeout_seq_err", 64'(seq_err), 64'd1);
        check("timeout_busy", 64'(busy), 64'd0);
        check("timeout_pc", 64'(pc), 64'd20);
        check("timeout_no_done", 64'(done_cnt - base), 64'd0);

        // Abort in IDLE is ignored.
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        check("idle_abort_busy", 64'(busy), 64'd0);
        check("idle_abort_err_kept", 64'(seq_err), 64'd1);

        // NOP at DEPTH-1: completes without wrap; start clears seq_err.
        base = done_cnt;
        pulse_start(5'd31);
        check("start_clears_err", 64'(seq_err), 64'd0);
        wait_seq_done("last_entry", 20);
        @(negedge clk);
        check("last_entry_pc", 64'(pc), 64'd31);
        check("last_entry_busy", 64'(busy), 64'd0);
        check("last_entry_done_count", 64'(done_cnt - base), 64'd1);
        model_en = 1'b1;

        // Abort during WAIT_LO (done held high after the clear).
        drop_en = 1'b0;
        write_entry(5'd22, ent(KIND_EXEC, 3'd6, mk(1, 2, 3, 12)));
        write_entry(5'd23, ent(KIND_HALT, 3'd0, '0));
        push(1'b0, mk(1, 2, 3, 12));
        push(1'b0, '0);
        push(1'b0, '0);
        base = done_cnt;
        pulse_start(5'd22);
        wait_strobe("abort_clear", 1'b1, 40, cyc);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_errclr_we0", 64'(core_if.cmd_we0), 64'd1);
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_seq_err", 64'(seq_err), 64'd1);
        check("abort_pc", 64'(pc), 64'd22);
        check("abort_no_done", 64'(done_cnt - base), 64'd0);
        model_en = 1'b0;
        repeat (2) @(negedge clk);
        drop_en = 1'b1;

        // Reset while in WAIT_HI: outputs all zero next cycle.
        write_entry(5'd24, ent(KIND_EXEC, 3'd1, mk(5, 6, 7, 10)));
        write_entry(5'd25, ent(KIND_HALT, 3'd0, '0));
        push(1'b0, mk(5, 6, 7, 10));
        pulse_start(5'd24);
        wait_strobe("rst_issue", 1'b0, 10, cyc);
        repeat (2) @(negedge clk);
        check("wait_hi_cmd_hold", 64'(core_if.cmd_out), 64'(mk(5, 6, 7, 10)));
        check("wait_hi_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("mid_rst");
        model_en = 1'b1;

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
